number_bcd_conv: RTL and testbench



---
 rtl/number_bcd_conv_pkg.sv | 23 ++
 rtl/number_bcd_conv_if.sv | 26 ++
 rtl/number_bcd_conv_bcd_add3_adj.sv | 9 +
 rtl/number_bcd_conv.sv | 123 ++++++++++++
 tb/tb_number_bcd_conv.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/number_bcd_conv_pkg.sv
// Shared constants and types for the binary-to-BCD number overlay path.
// Also consumed by the overlay for digit spacing and the blank-digit code.
package number_bcd_conv_pkg;

    localparam int unsigned DEF_BIN_W     = 13;
    localparam int unsigned DEF_MAX_VAL   = 999;
    localparam int unsigned DEF_CONV_BITS = 10;
    localparam int unsigned NUM_DIGITS    = 3;
    localparam int unsigned DIGIT_W       = 4;

    // Overlay draws nothing for this digit code
    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef struct packed {
        logic [DIGIT_W-1:0] hundreds;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd_digits_t;

endpackage

// File: rtl/number_bcd_conv_if.sv
// Value/vsync input and digit/status output bundle of the BCD converter.
interface number_bcd_conv_if #(
    parameter int unsigned BIN_W = number_bcd_conv_pkg::DEF_BIN_W
);
    import number_bcd_conv_pkg::*;

    logic               vsync_in;
    logic [BIN_W-1:0]   number_in;
    logic [DIGIT_W-1:0] digit_hundreds;
    logic [DIGIT_W-1:0] digit_tens;
    logic [DIGIT_W-1:0] digit_ones;
    logic               busy;
    logic               done;
    logic               overflow;

    modport master (
        output vsync_in, number_in,
        input  digit_hundreds, digit_tens, digit_ones, busy, done, overflow
    );

    modport slave (
        input  vsync_in, number_in,
        output digit_hundreds, digit_tens, digit_ones, busy, done, overflow
    );

endinterface

// File: rtl/number_bcd_conv_bcd_add3_adj.sv
// Double-dabble nibble correction: add 3 when the nibble is 5 or more.
module bcd_add3_adj (
    input  logic [3:0] nibble,
    output logic [3:0] adj_c
);

    assign adj_c = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/number_bcd_conv.sv
// Sequential binary-to-BCD converter, retriggered on each vsync rising edge.
// Build option NUMBER_BCD_LEADING_BLANK_EN replaces leading zero digits with DIGIT_BLANK.
module number_bcd_conv
    import number_bcd_conv_pkg::*;
#(
    parameter int unsigned BIN_W     = DEF_BIN_W,
    parameter int unsigned MAX_VAL   = DEF_MAX_VAL,
    parameter int unsigned CONV_BITS = DEF_CONV_BITS
) (
    input  logic             clk,
    input  logic             rst,
    number_bcd_conv_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);

    logic [0:0]           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [CONV_BITS-1:0] shreg, shreg_n;
    bcd_digits_t          bcd, bcd_n;
    bcd_digits_t          digits, digits_n;
    logic                 busy, busy_n;
    logic                 done, done_n;
    logic                 overflow, overflow_n;
    logic                 vsync_prev;

    logic                 trigger_c;
    logic                 over_c;
    logic [CONV_BITS-1:0] capture_c;
    bcd_digits_t          bcd_adj_c;
    bcd_digits_t          bcd_shift_c;
    logic                 unused_carry_c;

    assign trigger_c = bus.vsync_in & ~vsync_prev;
    assign over_c    = bus.number_in > BIN_W'(MAX_VAL);
    assign capture_c = over_c ? CONV_BITS'(MAX_VAL) : CONV_BITS'(bus.number_in);

    bcd_add3_adj u_adj_hundreds (.nibble(bcd.hundreds), .adj_c(bcd_adj_c.hundreds));
    bcd_add3_adj u_adj_tens     (.nibble(bcd.tens),     .adj_c(bcd_adj_c.tens));
    bcd_add3_adj u_adj_ones     (.nibble(bcd.ones),     .adj_c(bcd_adj_c.ones));

    // Inter-nibble carries ride the shift; the top one never sets while MAX_VAL fits 3 digits
    assign bcd_shift_c    = {bcd_adj_c[10:0], shreg[CONV_BITS-1]};
    assign unused_carry_c = bcd_adj_c.hundreds[3];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bcd        <= '0;
            digits     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            vsync_prev <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            bcd        <= bcd_n;
            digits     <= digits_n;
            busy       <= busy_n;
            done       <= done_n;
            overflow   <= overflow_n;
            vsync_prev <= bus.vsync_in;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        bcd_n      = bcd;
        digits_n   = digits;
        busy_n     = busy;
        done_n     = 1'b0;
        overflow_n = overflow;

        case (state)
            ST_IDLE: begin
                if (trigger_c) begin
                    shreg_n    = capture_c;
                    overflow_n = over_c;
                    bcd_n      = '0;
                    cnt_n      = '0;
                    busy_n     = 1'b1;
                    state_n    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_n   = bcd_shift_c;
                shreg_n = {shreg[CONV_BITS-2:0], 1'b0};
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(CONV_BITS - 1)) begin
                    digits_n = bcd_shift_c;
`ifdef NUMBER_BCD_LEADING_BLANK_EN
                    if (bcd_shift_c.hundreds == 4'd0) begin
                        digits_n.hundreds = DIGIT_BLANK;
                        if (bcd_shift_c.tens == 4'd0) begin
                            digits_n.tens = DIGIT_BLANK;
                        end
                    end
`endif
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.digit_hundreds = digits.hundreds;
    assign bus.digit_tens     = digits.tens;
    assign bus.digit_ones     = digits.ones;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.overflow       = overflow;

endmodule

// File: tb/tb_number_bcd_conv.sv
// Scoreboard bench for number_bcd_conv: expected digits are queued at each trigger
// and compared, with latency, when done pulses.
module tb_number_bcd_conv;

    typedef struct {
        logic [11:0] digits;
        logic        ovf;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_cnt = 0;
    exp_t        sb[$];

    number_bcd_conv_if bus ();

    number_bcd_conv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t make_exp(input int unsigned v, input int unsigned due);
        exp_t        e;
        int unsigned s;
        int unsigned h;
        int unsigned t;
        int unsigned o;
        s = (v > 999) ? 999 : v;
        h = s / 100;
        t = (s / 10) % 10;
        o = s % 10;
`ifdef NUMBER_BCD_LEADING_BLANK_EN
        if (h == 0) begin
            if (t == 0) t = 15;
            h = 15;
        end
`endif
        e.digits = {4'(h), 4'(t), 4'(o)};
        e.ovf    = (v > 999);
        e.due    = due;
        return e;
    endfunction

    // Output monitor: scoreboard compare on done, pulse width and digit stability
    logic [11:0] last_digits = '0;
    logic        done_prev = 1'b0;
    always @(negedge clk) begin
        logic [11:0] cur;
        exp_t        e;
        cur = {bus.digit_hundreds, bus.digit_tens, bus.digit_ones};
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_prev) check("done_width", 32'(done_prev), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("digits", 32'(cur), 32'(e.digits));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
                check("latency", cyc, e.due);
            end
            last_digits = cur;
        end else if (rst) begin
            last_digits = cur;
        end else if (cur !== last_digits) begin
            check("digit_hold", 32'(cur), 32'(last_digits));
            last_digits = cur;
        end
        done_prev = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising vsync with value v; leaves the bench in cycle T+1
    task automatic start_conv(input int unsigned v);
        bus.vsync_in = 1'b0;
        tick();
        bus.number_in = 13'(v);
        bus.vsync_in  = 1'b1;
        sb.push_back(make_exp(v, cyc + 11));
        tick();
        check("busy_t1", 32'(bus.busy), 32'd1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 40) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        tick();
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic convert(input int unsigned v);
        start_conv(v);
        drain();
    endtask

    initial begin
        int unsigned d0;
        rst           = 1'b1;
        bus.vsync_in  = 1'b1;
        bus.number_in = '0;
        repeat (3) tick();
        check("rst_digits", 32'({bus.digit_hundreds, bus.digit_tens, bus.digit_ones}), 32'd0);
        check("rst_flags", 32'({bus.busy, bus.done, bus.overflow}), 32'd0);

        // vsync high across reset release must not trigger
        rst = 1'b0;
        repeat (6) tick();
        check("no_trig_done", done_cnt, 32'd0);
        check("no_trig_busy", 32'(bus.busy), 32'd0);
        check("no_trig_digits", 32'({bus.digit_hundreds, bus.digit_tens, bus.digit_ones}), 32'd0);

        convert(123);
        convert(999);
        convert(0);
        convert(5000);
        check("ovf_held", 32'(bus.overflow), 32'd1);
        convert(42);
        convert(1000);
        convert(8191);
        convert(5);
        for (int i = 0; i < 4; i++) convert($urandom_range(0, 8191));

        // Second edge at T+4 and new value at T+2 are both ignored
        d0 = done_cnt;
        start_conv(555);
        tick();
        bus.number_in = 13'd777;
        bus.vsync_in  = 1'b0;
        tick();
        tick();
        bus.vsync_in = 1'b1;
        drain();
        repeat (15) tick();
        check("single_done", done_cnt - d0, 32'd1);

        // Reset at T+5 aborts without done
        start_conv(456);
        repeat (4) tick();
        rst = 1'b1;
        d0  = done_cnt;
        tick();
        sb.delete();
        check("abort_digits", 32'({bus.digit_hundreds, bus.digit_tens, bus.digit_ones}), 32'd0);
        check("abort_flags", 32'({bus.busy, bus.done, bus.overflow}), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        check("abort_no_done", done_cnt, d0);
        convert(456);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
